// File: rtl/pe_link_pkg.sv
// Shared definitions for the inter-tile PE link (tx and rx ends).
// The link word is valid, then credit, then payload, from MSB down.
package pe_link_pkg;

  localparam int DEF_LINK_WIDTH  = 130;
  localparam int DEF_DATA_WIDTH  = 128;
  localparam int LINK_VALID_BIT  = 129;
  localparam int LINK_CREDIT_BIT = 128;
  localparam int LINK_DATA_MSB   = 127;

  typedef struct packed {
    logic                   valid;
    logic                   credit;
    logic [LINK_DATA_MSB:0] data;
  } link_word_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_RUN  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/pe_credit_counter.sv
// Saturating up/down credit counter, starts full at RX_DEPTH.
// An increment while already full is dropped and flagged on ovf_pulse.
module pe_credit_counter #(
  parameter int RX_DEPTH  = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 nonzero,
  output logic                 ovf_pulse
);

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(RX_DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // Simultaneous dec and inc cancel; callers never dec at zero.
  always_comb begin
    count_d   = count_q;
    ovf_pulse = 1'b0;
    if (dec && !inc) begin
      count_d = count_q - ONE;
    end else if (inc && !dec) begin
      if (count_q == FULL) ovf_pulse = 1'b1;
      else                 count_d   = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= FULL;
    else       count_q <= count_d;
  end

  assign count   = count_q;
  assign nonzero = (count_q != '0);

endmodule

// File: rtl/pe_link_tx.sv
// Transmit end of the PE link: credit-gated valid/ready to registered link word,
// plus one-cycle forwarding of the local receiver's credit return.
//
// state   | meaning
// TX_IDLE | waiting for first ap_start, s_ready held low
// TX_RUN  | transmitting whenever credits are available
module pe_link_tx
  import pe_link_pkg::*;
#(
  parameter int LINK_WIDTH = DEF_LINK_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RX_DEPTH   = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  local_credit_ret,
  input  logic [LINK_WIDTH-1:0] in_from_peer,
  output logic [LINK_WIDTH-1:0] out_to_peer,
  output logic [CNT_WIDTH-1:0]  credits,
  output logic [31:0]           tx_count,
  output logic                  err_credit_ovf
);

  tx_state_t  state_q;
  tx_state_t  state_d;
  logic       started;
  logic       crd_in;
  logic       send;
  logic       cnt_nonzero;
  logic       ovf_pulse;
  link_word_t out_d;
  link_word_t out_q;
  logic       unused_peer;

  always_ff @(posedge clk) begin
    if (reset) state_q <= TX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE: if (ap_start) state_d = TX_RUN;
      TX_RUN:  state_d = TX_RUN;
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    started = (state_q == TX_RUN);
  end

  // Only the credit bit of the reverse link matters on this end.
  assign crd_in      = in_from_peer[LINK_CREDIT_BIT];
  assign unused_peer = ^{in_from_peer[LINK_WIDTH-1:LINK_CREDIT_BIT+1],
                         in_from_peer[LINK_DATA_MSB:0]};

  pe_credit_counter #(
    .RX_DEPTH (RX_DEPTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_credit (
    .clk      (clk),
    .reset    (reset),
    .dec      (send),
    .inc      (crd_in),
    .count    (credits),
    .nonzero  (cnt_nonzero),
    .ovf_pulse(ovf_pulse)
  );

  assign s_ready = started && cnt_nonzero;
  assign send    = s_valid && s_ready;

  always_comb begin
    out_d.valid  = send;
    out_d.credit = local_credit_ret;
    out_d.data   = send ? s_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q          <= '0;
      tx_count       <= '0;
      err_credit_ovf <= 1'b0;
    end else begin
      out_q <= out_d;
      if (send)      tx_count       <= tx_count + 32'd1;
      if (ovf_pulse) err_credit_ovf <= 1'b1;
    end
  end

  assign out_to_peer = out_q;

endmodule
